// File: rtl/tsbus_pkg.sv
// Shared types and helpers for the tri-state bus port controller.
//   state_e : port FSM states
//   clog2   : ceiling log2 with a floor of 1, used for counter and pointer widths
package tsbus_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StTurnTx = 2'd1,
        StDrive  = 2'd2,
        StTurnRx = 2'd3
    } state_e;

    // Never returns 0 so a one-value range still gets a legal 1-bit vector.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << res) < 64'(value)) begin
                res = res + 1;
            end
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tsbus_rx_fifo.sv
// Receive FIFO for beats captured from the far end of the bus.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and beat; ignored when full unless pop_i is also set
//   pop_i         : read request; ignored when empty
//   data_o        : head entry (0 after reset)
//   full_o/empty_o: occupancy flags
module tsbus_rx_fifo
    import tsbus_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW     = clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         wr_en;
    logic         rd_en;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/tsbus_port_ctrl.sv
// Controller for one end of a shared half-duplex tri-state bus built from bus-switch cells.
// Drives the cell enable and launch values, enforces turnaround gaps around every drive
// window and captures far-end beats into a receive FIFO.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   bus_in_i, bus_vld_in_i     : resolved bus data / strobe from the pads
//   bus_out_o, bus_vld_out_o   : launched data / strobe (registered)
//   bus_oe_o                   : enable for all bus-switch cells (registered)
//   tx_req_i, tx_data_i        : core transmit request and beat
//   tx_ack_o                   : beat consumed this cycle (combinational)
//   rx_data_o, rx_vld_o        : receive FIFO head / non-empty
//   rx_rdy_i                   : core pops head when rx_vld_o && rx_rdy_i
//   rx_ovf_o                   : sticky, a captured beat was dropped
module tsbus_port_ctrl
    import tsbus_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TURN  = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] bus_in_i,
    input  logic         bus_vld_in_i,
    output logic [W-1:0] bus_out_o,
    output logic         bus_vld_out_o,
    output logic         bus_oe_o,
    input  logic         tx_req_i,
    input  logic [W-1:0] tx_data_i,
    output logic         tx_ack_o,
    output logic [W-1:0] rx_data_o,
    output logic         rx_vld_o,
    input  logic         rx_rdy_i,
    output logic         rx_ovf_o
);

    localparam int unsigned   CW      = clog2(TURN);
    localparam logic [CW-1:0] CntLast = CW'(TURN - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    state_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         bus_oe_q, bus_oe_d;
    logic         bus_vld_out_q, bus_vld_out_d;
    logic [W-1:0] bus_out_q, bus_out_d;
    logic         rx_ovf_q, rx_ovf_d;
    logic         tx_ack;

    logic         rx_push;
    logic         rx_pop;
    logic         rx_full;
    logic         rx_empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_ack  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_req_i && !bus_vld_in_i) begin
                    state_d = StTurnTx;
                    cnt_d   = '0;
                end
            end
            StTurnTx: begin
                // Far end started driving: yield, keep the request pending.
                if (bus_vld_in_i) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d = StDrive;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StDrive: begin
                if (tx_req_i) begin
                    tx_ack = 1'b1;
                end else begin
                    state_d = StTurnRx;
                    cnt_d   = '0;
                end
            end
            StTurnRx: begin
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Enable follows the drive window: rises on entry, falls on the release edge.
        bus_oe_d      = (state_d == StDrive);
        bus_vld_out_d = tx_ack;
        bus_out_d     = tx_ack ? tx_data_i : bus_out_q;
    end

    // Own strobe echoes back while driving, so capture is suppressed in StDrive.
    assign rx_push = bus_vld_in_i && (state_q != StDrive);
    assign rx_pop  = !rx_empty && rx_rdy_i;

    always_comb begin
        rx_ovf_d = rx_ovf_q;
        if (rx_push && rx_full && !rx_pop) begin
            rx_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bus_oe_q      <= 1'b0;
            bus_vld_out_q <= 1'b0;
            bus_out_q     <= '0;
            rx_ovf_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_oe_q      <= bus_oe_d;
            bus_vld_out_q <= bus_vld_out_d;
            bus_out_q     <= bus_out_d;
            rx_ovf_q      <= rx_ovf_d;
        end
    end

    tsbus_rx_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rx_push),
        .data_i  (bus_in_i),
        .pop_i   (rx_pop),
        .data_o  (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign bus_oe_o      = bus_oe_q;
    assign bus_vld_out_o = bus_vld_out_q;
    assign bus_out_o     = bus_out_q;
    assign tx_ack_o      = tx_ack;
    assign rx_vld_o      = !rx_empty;
    assign rx_ovf_o      = rx_ovf_q;

endmodule
